// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel/address types and clear FSM states
package fb_pkg;
    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 16;
    typedef logic [2:0] pixel_t;
    typedef logic [FB_ADDR_W-1:0] addr_t;
    typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: fills every framebuffer pixel with a latched colour, one per unstalled cycle
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int FB_SIZE = fb_pkg::FB_SIZE
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start_i,
    input  pixel_t color_i,
    input  logic   stall_i,
    output logic   busy_o,
    output addr_t  ptr_o,
    output pixel_t color_o
);
    localparam addr_t LAST = addr_t'(FB_SIZE - 1);
    clr_state_t state_q;
    addr_t ptr_q;
    pixel_t color_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            color_q <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                state_q <= CLEAR;
                ptr_q   <= '0;
                color_q <= color_i;
            end
        end else if (!stall_i) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == LAST) state_q <= IDLE;
        end
    end
    assign busy_o  = state_q == CLEAR;
    assign ptr_o   = ptr_q;
    assign color_o = color_q;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM shared by VGA scanout, clear engine and CPU
// (priority VGA > CLEAR > CPU, one access per cycle).
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FB_SIZE = fb_pkg::FB_SIZE
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   vga_req,
    input  addr_t  vga_addr,
    output pixel_t vga_pixel,
    input  logic   cpu_valid,
    input  logic   cpu_we,
    input  addr_t  cpu_addr,
    input  pixel_t cpu_wdata,
    output logic   cpu_ready,
    output logic   cpu_rvalid,
    output pixel_t cpu_rdata,
    output logic   cpu_err,
    input  logic   clr_start,
    input  pixel_t clr_color,
    output logic   clr_busy,
    output addr_t  ram_addr,
    output logic   ram_we,
    output pixel_t ram_wdata,
    input  pixel_t ram_rdata
);
    localparam addr_t LAST = addr_t'(FB_SIZE - 1);
    logic vga_req_q, pend_q, vga_rd_q, cpu_rd_q, cpu_oor_q;
    addr_t vga_last_q, clr_ptr;
    pixel_t clr_col;
    logic grant, cpu_acc, in_range;
    assign grant     = vga_req && (vga_addr != vga_last_q || pend_q);
    assign cpu_ready = !clr_busy && !grant;
    assign cpu_acc   = cpu_valid && cpu_ready;
    assign in_range  = cpu_addr <= LAST;
    assign ram_addr  = grant ? vga_addr : clr_busy ? clr_ptr : cpu_addr;
    // a reset cycle never writes, so an abandoned fill stops at the current pointer
    assign ram_we    = !rst && !grant && (clr_busy || (cpu_acc && cpu_we && in_range));
    assign ram_wdata = clr_busy ? clr_col : cpu_wdata;
    fb_clear_engine #(.FB_SIZE(FB_SIZE)) u_clear (
        .clk    (clk),
        .rst    (rst),
        .start_i(clr_start),
        .color_i(clr_color),
        .stall_i(grant),
        .busy_o (clr_busy),
        .ptr_o  (clr_ptr),
        .color_o(clr_col)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_req_q  <= 1'b0;
            pend_q     <= 1'b0;
            vga_last_q <= '1;
            vga_rd_q   <= 1'b0;
            cpu_rd_q   <= 1'b0;
            cpu_oor_q  <= 1'b0;
            vga_pixel  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_err    <= 1'b0;
        end else begin
            vga_req_q  <= vga_req;
            pend_q     <= !grant && (pend_q || (vga_req && !vga_req_q));
            if (grant) vga_last_q <= vga_addr;
            vga_rd_q   <= grant;
            cpu_rd_q   <= cpu_acc && !cpu_we && in_range;
            cpu_oor_q  <= cpu_acc && !in_range;
            if (vga_rd_q) vga_pixel <= ram_rdata;
            cpu_rvalid <= cpu_rd_q || cpu_oor_q;
            cpu_rdata  <= cpu_rd_q ? ram_rdata : '0;
            cpu_err    <= cpu_oor_q;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed stimulus with a queue scoreboard for CPU responses and VGA pixels
module tb_fb_arbiter;
    import fb_pkg::*;
    localparam int N = 34240;
    logic clk = 1'b0, rst = 1'b1;
    logic vga_req = 1'b0, cpu_valid = 1'b0, cpu_we = 1'b0, clr_start = 1'b0;
    addr_t vga_addr = '0, cpu_addr = '0, ram_addr;
    pixel_t cpu_wdata = '0, clr_color = '0, vga_pixel, cpu_rdata, ram_wdata, ram_rdata;
    logic cpu_ready, cpu_rvalid, cpu_err, clr_busy, ram_we;
    logic [2:0] mem [0:65535];
    int cyc = 0;
    int checks = 0, failures = 0;
    typedef struct packed { int cyc; logic [2:0] d; logic e; } exp_t;
    exp_t cq[$];
    exp_t vq[$];

    fb_arbiter dut (
        .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr), .vga_pixel(vga_pixel),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model, preloaded with addr%8 on the first edge
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 3'(i % 8);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cpu_rvalid) begin
                checks++;
                if (cq.size() == 0) begin
                    failures++;
                    $display("FAIL cpu_unexpected_rvalid: got rdata=%0d err=%0d at cycle %0d", cpu_rdata, cpu_err, cyc);
                end else begin
                    e = cq.pop_front();
                    if (e.cyc != cyc || cpu_rdata !== e.d || cpu_err !== e.e) begin
                        failures++;
                        $display("FAIL cpu_resp: got cyc=%0d rdata=%0d err=%0d expected cyc=%0d rdata=%0d err=%0d",
                                 cyc, cpu_rdata, cpu_err, e.cyc, e.d, e.e);
                    end
                end
            end else if (cq.size() > 0 && cq[0].cyc < cyc) begin
                e = cq.pop_front();
                checks++;
                failures++;
                $display("FAIL cpu_resp_missing: got no rvalid expected at cycle %0d", e.cyc);
            end
            if (vq.size() > 0 && vq[0].cyc <= cyc) begin
                e = vq.pop_front();
                checks++;
                if (e.cyc != cyc || vga_pixel !== e.d) begin
                    failures++;
                    $display("FAIL vga_pixel: got %0d expected %0d at cycle %0d", vga_pixel, e.d, e.cyc);
                end
            end
        end
    end

    initial begin
        int n, op, bad, bad2;
        bit rdy;
        repeat (3) tick;
        chk("rst_vga_pixel", 32'(vga_pixel), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_cpu_err", 32'(cpu_err), 0);
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        rst = 1'b0;
        tick;

        // VGA scanout steps 0,1,2
        vga_req = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k % 6 == 0) begin
                vga_addr = 16'(k / 6);
                vq.push_back('{cyc + 2, 3'(k / 6), 1'b0});
            end
            #1;
            chk("vga_slot_ready", 32'(cpu_ready), 32'(k % 6 != 0));
            tick;
        end

        // CPU write then read of address 100 while VGA keeps fetching
        op = 0;
        for (int k = 0; k < 24; k++) begin
            if (k % 6 == 0) begin
                vga_addr = 16'(200 + k / 6);
                vq.push_back('{cyc + 2, 3'((200 + k / 6) % 8), 1'b0});
            end
            cpu_valid = op < 2;
            cpu_we = op == 0;
            cpu_addr = 16'd100;
            cpu_wdata = 3'd5;
            #1;
            chk("cpu_ready_vs_slot", 32'(cpu_ready), 32'(k % 6 != 0));
            if (k % 6 == 0) chk("no_we_in_slot", 32'(ram_we), 0);
            if (cpu_valid && cpu_ready) begin
                if (cpu_we) chk("cpu_write_we", 32'(ram_we), 1);
                else cq.push_back('{cyc + 2, 3'd5, 1'b0});
                op++;
            end
            tick;
        end
        cpu_valid = 1'b0;
        chk("cpu_ops_done", 32'(op), 2);

        // out-of-range read and write
        vga_req = 1'b0;
        tick;
        cpu_valid = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'd34240;
        #1;
        chk("oor_read_ready", 32'(cpu_ready), 1);
        cq.push_back('{cyc + 2, 3'd0, 1'b1});
        tick;
        cpu_we = 1'b1;
        cpu_addr = 16'd40000;
        cpu_wdata = 3'd7;
        #1;
        chk("oor_write_no_we", 32'(ram_we), 0);
        cq.push_back('{cyc + 2, 3'd0, 1'b1});
        tick;
        cpu_valid = 1'b0;
        cpu_we = 1'b0;
        repeat (4) tick;

        // full clear to colour 3, second start ignored
        clr_color = 3'd3;
        clr_start = 1'b1;
        #1;
        chk("clr_busy_before", 32'(clr_busy), 0);
        tick;
        clr_start = 1'b0;
        n = 0;
        rdy = 1'b0;
        while (clr_busy === 1'b1 && n < 40000) begin
            rdy |= cpu_ready;
            clr_start = n == 500;
            clr_color = n == 500 ? 3'd7 : 3'd3;
            n++;
            tick;
        end
        clr_start = 1'b0;
        chk("clr_len", 32'(n), N);
        chk("clr_cpu_ready_low", 32'(rdy), 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 3'd3) bad++;
        chk("clr_fill_3", 32'(bad), 0);
        chk("clr_bound", 32'(mem[N + 1]), 1);
        chk("oor_write_untouched", 32'(mem[40000]), 0);

        // clear to colour 6 with VGA active; start coincides with a VGA fetch
        vga_req = 1'b1;
        vga_addr = 16'd34000;
        clr_color = 3'd6;
        clr_start = 1'b1;
        vq.push_back('{cyc + 2, 3'd3, 1'b0});
        #1;
        chk("sim_start_ready", 32'(cpu_ready), 0);
        tick;
        clr_start = 1'b0;
        chk("sim_enter_clear", 32'(clr_busy), 1);
        n = 0;
        while (clr_busy === 1'b1 && n < 40000) begin
            if ((n + 1) % 6 == 0 && (n + 1) / 6 <= 9) begin
                vga_addr = 16'(34000 + (n + 1) / 6);
                vq.push_back('{cyc + 2, 3'd3, 1'b0});
            end
            n++;
            tick;
        end
        chk("clr_vga_len", 32'(n), N + 9);
        vga_addr = 16'd34005;
        vq.push_back('{cyc + 2, 3'd6, 1'b0});
        repeat (3) tick;
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 3'd6) bad++;
        chk("clr_vga_fill_6", 32'(bad), 0);

        // reset at clear pointer 1000 abandons the fill
        vga_req = 1'b0;
        tick;
        clr_color = 3'd1;
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        repeat (1000) tick;
        rst = 1'b1;
        #1;
        chk("rst_no_we", 32'(ram_we), 0);
        tick;
        chk("rst_abandon_busy", 32'(clr_busy), 0);
        rst = 1'b0;
        tick;
        bad = 0;
        bad2 = 0;
        for (int i = 0; i < 1000; i++) if (mem[i] !== 3'd1) bad++;
        for (int i = 1000; i < N; i++) if (mem[i] !== 3'd6) bad2++;
        chk("partial_new", 32'(bad), 0);
        chk("partial_old", 32'(bad2), 0);

        repeat (5) tick;
        chk("scoreboard_drained", 32'(cq.size() + vq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
